// File: rtl/mdu_pkg.sv
// Shared op-codes, default latencies, state encoding and decode helper
// for the HI/LO multiply/divide unit.
package mdu_pkg;

  localparam logic [3:0] OP_NONE  = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    ST_IDLE,
    ST_BUSY
  } mdu_state_e;

  function automatic logic is_start_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 32x32 multiply and divide datapath; produces the 64-bit
// {hi,lo} result for the op presented and flags a zero divisor.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_zero
);

  logic        is_signed_div;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] divisor_safe;
  logic [31:0] q_u;
  logic [31:0] r_u;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] prod_s;
  logic [63:0] prod_u;

  assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
  assign prod_u = {32'd0, a} * {32'd0, b};

  // Signed divide works on magnitudes so 0x80000000 / -1 needs no special case.
  assign is_signed_div = (op == OP_DIV);
  assign a_mag         = a[31] ? (~a + 32'd1) : a;
  assign b_mag         = b[31] ? (~b + 32'd1) : b;
  assign dividend      = is_signed_div ? a_mag : a;
  assign divisor       = is_signed_div ? b_mag : b;
  assign divisor_safe  = (divisor == 32'd0) ? 32'd1 : divisor;
  assign q_u           = dividend / divisor_safe;
  assign r_u           = dividend % divisor_safe;
  assign quot          = (is_signed_div && (a[31] ^ b[31])) ? (~q_u + 32'd1) : q_u;
  assign rem           = (is_signed_div && a[31]) ? (~r_u + 32'd1) : r_u;

  always_comb begin
    result   = 64'd0;
    div_zero = 1'b0;
    case (op)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV, OP_DIVU: begin
        result   = {rem, quot};
        div_zero = (b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// HI/LO controller: issues MDU ops, counts fixed latency, commits the
// pending result to HI/LO and raises the D-stage stall.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  e_op,
  input  logic [31:0] e_rs,
  input  logic [31:0] e_rt,
  input  logic        d_md_use,
  output logic        busy,
  output logic        start,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] e_rd_data
);

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  mdu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] pend_q, pend_d;
  logic        pend_zero_q, pend_zero_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [63:0] arith_result;
  logic        arith_div_zero;

  mdu_arith u_arith (
    .op       (e_op),
    .a        (e_rs),
    .b        (e_rt),
    .result   (arith_result),
    .div_zero (arith_div_zero)
  );

  assign busy  = (state_q == ST_BUSY);
  assign start = is_start_op(e_op) & ~busy;
  assign stall = d_md_use & (busy | start);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_zero_d = pend_zero_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d     = ST_BUSY;
        pend_d      = arith_result;
        pend_zero_d = arith_div_zero;
        cnt_d       = ((e_op == OP_MULT) || (e_op == OP_MULTU)) ? MULT_N : DIV_N;
      end else if (e_op == OP_MTHI) begin
        hi_d = e_rs;
      end else if (e_op == OP_MTLO) begin
        lo_d = e_rs;
      end
    end else begin
      cnt_d = cnt_q - 4'd1;
      // Last busy cycle: commit unless the divisor was zero.
      if (cnt_q == 4'd1) begin
        state_d = ST_IDLE;
        if (!pend_zero_q) begin
          hi_d = pend_q[63:32];
          lo_d = pend_q[31:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      pend_q      <= 64'd0;
      pend_zero_q <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_zero_q <= pend_zero_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

  always_comb begin
    e_rd_data = 32'd0;
    if (e_op == OP_MFHI) e_rd_data = hi_q;
    else if (e_op == OP_MFLO) e_rd_data = lo_q;
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: directed ops push expected commits; a
// monitor checks HI/LO and busy length whenever busy falls.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [3:0]  e_op;
  logic [31:0] e_rs;
  logic [31:0] e_rt;
  logic        d_md_use;
  logic        busy;
  logic        start;
  logic        stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] e_rd_data;

  typedef struct {
    string       name;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .e_op      (e_op),
    .e_rs      (e_rs),
    .e_rt      (e_rt),
    .d_md_use  (d_md_use),
    .busy      (busy),
    .start     (start),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .e_rd_data (e_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expectCommit(input string name, input logic [31:0] h, input logic [31:0] l, input int cyc);
    exp_t e;
    e.name = name; e.hi = h; e.lo = l; e.cycles = cyc;
    sb.push_back(e);
  endtask

  // Drives one op for a single cycle, checking the start pulse before the edge.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] rs,
                               input logic [31:0] rt, input logic exp_start);
    @(posedge clk); #1;
    e_op = op; e_rs = rs; e_rt = rt;
    @(negedge clk);
    checkOutput({name, " start"}, 64'(start), 64'(exp_start));
    @(posedge clk); #1;
    e_op = OP_NONE;
  endtask

  task automatic waitIdle(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < budget);
    if (busy) checkOutput("idle timeout", 64'(busy), 64'd0);
  endtask

  // Monitor: measures each busy window and checks the commit when it ends.
  initial begin
    int   len = 0;
    logic prev = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev = 1'b0;
        len  = 0;
      end else begin
        if (busy) len++;
        else if (prev) begin
          if (sb.size() == 0) checkOutput("unexpected commit", 64'd1, 64'd0);
          else begin
            e = sb.pop_front();
            checkOutput({e.name, " hi"}, 64'(hi), 64'(e.hi));
            checkOutput({e.name, " lo"}, 64'(lo), 64'(e.lo));
            checkOutput({e.name, " busy cycles"}, 64'(len), 64'(e.cycles));
          end
          len = 0;
        end
        prev = busy;
      end
    end
  end

  initial begin
    int n;
    reset_n = 1'b0; e_op = OP_NONE; e_rs = 32'd0; e_rt = 32'd0; d_md_use = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset stall", 64'(stall), 64'd0);

    // 1: signed multiply of -2 * 3
    expectCommit("MULT", 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
    applyStimulus("MULT", OP_MULT, 32'hFFFFFFFE, 32'd3, 1'b1);
    checkOutput("MULT start drop", 64'(start), 64'd0);
    waitIdle(20);

    // 2: unsigned multiply with the D stage using the MDU throughout
    d_md_use = 1'b1;
    expectCommit("MULTU", 32'hFFFFFFFE, 32'h00000001, 5);
    @(posedge clk); #1;
    e_op = OP_MULTU; e_rs = 32'hFFFFFFFF; e_rt = 32'hFFFFFFFF;
    @(negedge clk);
    checkOutput("MULTU issue stall", 64'(stall), 64'd1);
    @(posedge clk); #1;
    e_op = OP_NONE;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (stall) n++;
    end
    checkOutput("MULTU busy stall cycles", 64'(n), 64'd5);
    checkOutput("MULTU stall after", 64'(stall), 64'd0);
    d_md_use = 1'b0;

    // 3: signed and unsigned divide
    expectCommit("DIV", 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
    applyStimulus("DIV", OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    waitIdle(20);
    expectCommit("DIVU", 32'd1, 32'd3, 10);
    applyStimulus("DIVU", OP_DIVU, 32'd7, 32'd2, 1'b1);
    waitIdle(20);

    // 4: moves, then divide by zero must leave HI/LO alone
    applyStimulus("MTHI", OP_MTHI, 32'h1234, 32'd0, 1'b0);
    checkOutput("MTHI hi", 64'(hi), 64'h1234);
    applyStimulus("MTLO", OP_MTLO, 32'h5678, 32'd0, 1'b0);
    checkOutput("MTLO lo", 64'(lo), 64'h5678);
    checkOutput("MTLO hi kept", 64'(hi), 64'h1234);
    expectCommit("DIVU by zero", 32'h1234, 32'h5678, 10);
    applyStimulus("DIVU0", OP_DIVU, 32'd5, 32'd0, 1'b1);
    waitIdle(20);
    @(posedge clk); #1;
    e_op = OP_MFHI;
    @(negedge clk);
    checkOutput("MFHI data", 64'(e_rd_data), 64'h1234);
    @(posedge clk); #1;
    e_op = OP_MFLO;
    @(negedge clk);
    checkOutput("MFLO data", 64'(e_rd_data), 64'h5678);
    @(posedge clk); #1;
    e_op = OP_NONE;
    @(negedge clk);
    checkOutput("NONE data", 64'(e_rd_data), 64'd0);

    // 5: reset in the third busy cycle discards the multiply
    applyStimulus("MULT abort", OP_MULT, 32'd2, 32'd3, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(negedge clk);
    checkOutput("abort busy", 64'(busy), 64'd0);
    checkOutput("abort hi", 64'(hi), 64'd0);
    checkOutput("abort lo", 64'(lo), 64'd0);
    expectCommit("MULT after reset", 32'd0, 32'd6, 5);
    applyStimulus("MULT2", OP_MULT, 32'd2, 32'd3, 1'b1);
    waitIdle(20);

    // 6: overflow divide, with a start-type op presented while busy
    expectCommit("DIV overflow", 32'd0, 32'h80000000, 10);
    applyStimulus("DIVOVF", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1);
    e_op = OP_DIVU; e_rs = 32'd100; e_rt = 32'd7;
    @(negedge clk);
    checkOutput("busy DIVU start", 64'(start), 64'd0);
    checkOutput("busy DIVU busy", 64'(busy), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("busy DIVU start 2", 64'(start), 64'd0);
    @(posedge clk); #1;
    e_op = OP_NONE;
    waitIdle(20);

    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Controller for the HI/LO multiply/divide unit of the pipelined CPU.
- Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the E stage.
- Runs a fixed-latency busy sequence per operation, then commits the result to the architectural HI/LO registers.
- Generates the decode-stage stall request, so MDU instructions never observe or overwrite an in-flight result.

Parameters:
MULT_CYCLES, 5, busy cycles for MULT/MULTU (legal range 1..15)
DIV_CYCLES, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  synchronous active-low reset
e_op  input  4  E-stage MDU op: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; 9..15 treated as NONE
e_rs  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source)
e_rt  input  32  rt operand (divisor / multiplier)
d_md_use  input  1  D-stage instruction is any MDU op
busy  output  1  operation in flight
start  output  1  one-cycle pulse, high in the cycle a MULT/MULTU/DIV/DIVU is accepted
stall  output  1  stall request to D stage
hi  output  32  architectural HI
lo  output  32  architectural LO
e_rd_data  output  32  MFHI -> hi, MFLO -> lo, otherwise 0 (combinational)

Behaviour:
- Reset (reset_n=0 at an edge): busy=0, counter=0, pending result=0, hi=0, lo=0. Takes priority over everything, including mid-operation; the in-flight result is discarded.
- Combinational outputs:
  - start = (e_op in 1..4) & ~busy.
  - stall = d_md_use & (busy | start).
- Issue:
  - At an edge with start=1, latch the 64-bit result from mdu_arith into the pending register.
  - Load counter = N (MULT_CYCLES or DIV_CYCLES) and set busy=1.
  - A start-type e_op while busy=1 is ignored (no pending/counter change). The stall logic makes this unreachable in a correct pipeline.
- Count:
  - While busy, decrement counter each edge.
  - At the edge where counter==1: busy<=0, hi<=pending[63:32], lo<=pending[31:0].
  - busy is therefore high for exactly N cycles after the issue edge. hi/lo change at the same edge that busy falls.
- Arithmetic (in mdu_arith):
  - MULT: signed 32x32 -> 64. MULTU: unsigned 32x32 -> 64.
  - DIV: lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: unsigned quotient/remainder.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Divide by zero: busy sequence runs normally, but the commit is suppressed and hi/lo keep their old values. A div_zero flag is latched with the pending result.
- MTHI/MTLO: when busy=0, write e_rs to hi/lo at the edge. When busy=1, ignored (unreachable under stall).
- MFHI/MFLO: read-only, no state change. Value is valid only when busy=0.
- Simultaneous events:
  - The commit edge and a new start cannot coincide, because start requires busy=0.
  - The first start is legal in the cycle after busy falls.
  - An MTHI at the edge after commit overwrites the committed hi.

Decomposition:
- Package mdu_pkg:
  - op-code localparams: OP_NONE..OP_MTLO.
  - default latency constants: MULT_CYCLES_DEF=5, DIV_CYCLES_DEF=10.
  - helper function is_start_op(op).
- Sub-module mdu_arith: purely combinational.
  - Inputs: op, a, b.
  - Outputs: result[63:0], div_zero.
  - mdu_ctrl holds all sequential state (counter, busy, pending, hi, lo).

Test Plan:
1. Reset, then MULT rs=0xFFFFFFFE, rt=3 -> start pulse 1 cycle; busy high exactly 5 cycles; hi=0xFFFFFFFF, lo=0xFFFFFFFA on the edge busy falls.
2. MULTU rs=0xFFFFFFFF, rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles. With d_md_use=1 throughout, stall=1 in the issue cycle plus all 5 busy cycles, and 0 after.
3. DIV rs=0xFFFFFFF9 (-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU rs=7, rt=2 -> lo=3, hi=1.
4. MTHI 0x1234, MTLO 0x5678, then DIVU rs=5, rt=0 -> busy 10 cycles; hi=0x1234, lo=0x5678 unchanged; MFHI gives e_rd_data=0x1234.
5. MULT issued, reset_n=0 on 3rd busy cycle -> next cycle busy=0, hi=lo=0; a following MULT runs a full 5 cycles.
6. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU issued while busy (stall forced off) -> ignored, original result committed on schedule.
